pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage pipelined CPU. Consumes the IDStall/EXStall hazard flags, ID-stage branch/jump resolution and the data-memory ready handshake.
- Drives write-enable and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the post-reset pipeline fill sequence, memory-wait freezing, and a watchdog that traps deadlocked stalls or hung memory.

Parameters:
FILL_CYCLES, 4, cycles of forced bubbles into ID/EX after reset release
MEM_TIMEOUT, 16, max consecutive dmem_ready-low cycles in MEM_WAIT before fault
MAX_STALL, 8, max consecutive IDStall/EXStall cycles before fault
CNT_W, 5, width of internal fill/timeout/stall counters (must hold max of above)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
IDStall  in  1  ID-stage hazard from stall detector
EXStall  in  1  EX-stage load-use hazard from stall detector
branch_taken  in  1  BEQ/BNE resolved taken in ID
jump  in  1  J decoded in ID
dmem_req  in  1  MEM stage holds LW/SW
dmem_ready  in  1  data memory completes access this cycle
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID load NOP
idex_we  out  1  ID/EX write enable
idex_bubble  out  1  ID/EX load NOP
exmem_we  out  1  EX/MEM write enable
exmem_bubble  out  1  EX/MEM load NOP
memwb_bubble  out  1  MEM/WB load NOP
fault  out  1  sticky watchdog trap
fault_code  out  2  00 none, 01 mem timeout, 10 stall deadlock
state_o  out  3  current FSM state (debug)

Behaviour:
- State register and counters update on rising clk; control outputs combinational from state plus current inputs (same-cycle effect on pipeline registers).
- States: FILL=0, RUN=1, MEM_WAIT=2, FAULT=3.
- Reset (async, any time, including mid-MEM_WAIT): state=FILL, counters=0, fault=0, fault_code=00.
  - Outputs during reset: pc_we=0, all *_we=0, all bubbles/flush=1.
- FILL: pc_we=1, ifid_we=1, idex_bubble=1, exmem_we=1. Hazard inputs ignored. After FILL_CYCLES cycles -> RUN. FILL_CYCLES=0 -> RUN on first clock.
- RUN priority, highest first:
  1. dmem_req & !dmem_ready: all we=0, memwb_bubble=1; next state MEM_WAIT.
  2. EXStall: pc_we=ifid_we=idex_we=0, exmem_bubble=1.
  3. IDStall: pc_we=ifid_we=0, idex_bubble=1.
  4. branch_taken|jump: ifid_flush=1, all we=1.
  5. Otherwise: all we=1, no bubbles.
- A stall suppresses a concurrent branch/jump flush; the branch is re-evaluated when the stall clears.
- MEM_WAIT:
  - Same outputs as priority 1 while dmem_ready=0.
  - dmem_ready=1: outputs as RUN evaluated that cycle; next state RUN.
  - Wait counter increments each dmem_ready-low cycle. Reaching MEM_TIMEOUT -> FAULT, fault_code=01.
- Stall watchdog: counts consecutive RUN cycles with (IDStall|EXStall) and no mem wait. Clears on any non-stall cycle. Reaching MAX_STALL -> FAULT, fault_code=10.
- FAULT: all we=0, all bubbles=1, fault=1. Held until rst.
- Counters saturate and never wrap.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- Defined: four 32-bit counters, reset to 0, wrap modulo 2^32:
  - perf_id_stall: cycles priority 3 active
  - perf_ex_stall: cycles priority 2 active
  - perf_mem_wait: cycles in MEM_WAIT with dmem_ready=0
  - perf_flush: cycles with ifid_flush=1
- Counters exposed as 32-bit outputs of the same names.
- Undefined: the same output ports exist but are tied to 0; no counter flops are synthesized.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encodings FILL/RUN/MEM_WAIT/FAULT
  - fault_code constants
  - the opcode constants LW, SW, RTYPE, BEQ, BNE, J, ADDI, SLTI, LUI, used by the dmem_req decoder upstream
- One sub-module, hazard_watchdog: saturating counter + compare, instantiated twice (mem timeout, stall deadlock).

Test Plan:
- Reset release, no hazards -> idex_bubble=1 for exactly 4 cycles, then state_o=1 with all we=1 and no bubbles.
- In RUN, IDStall=1 with branch_taken=1 for 1 cycle -> pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0. Next cycle IDStall=0, branch_taken=1 -> ifid_flush=1.
- In RUN, EXStall=1 for 2 cycles -> pc_we=ifid_we=idex_we=0 and exmem_bubble=1 both cycles, then all we=1.
- dmem_req=1, dmem_ready low 3 cycles then high -> state_o=2 for 3 cycles, memwb_bubble=1, all we=0; RUN on ready, no fault.
- dmem_ready held low 16 cycles -> fault=1, fault_code=01, state_o=3. rst pulse mid-FAULT -> state_o=0, fault=0.
- IDStall held 8 cycles -> fault_code=10. With HAZARD_PERF_COUNTERS_EN, perf_id_stall=8 at the fault.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: sequencer state
// encodings, watchdog fault codes and the instruction opcodes that the
// upstream dmem_req / branch decoders key on.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    FILL     = 3'd0,
    RUN      = 3'd1,
    MEM_WAIT = 3'd2,
    FAULT    = 3'd3
  } ctrl_state_t;

  localparam logic [1:0] FAULT_NONE           = 2'b00;
  localparam logic [1:0] FAULT_MEM_TIMEOUT    = 2'b01;
  localparam logic [1:0] FAULT_STALL_DEADLOCK = 2'b10;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] SLTI  = 6'b001010;
  localparam logic [5:0] LUI   = 6'b001111;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

  // Opcodes that occupy the data-memory port in MEM (source of dmem_req).
  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == LW) || (opcode == SW);
  endfunction

  // Conditional branches resolved in ID.
  function automatic logic is_branch_op(input logic [5:0] opcode);
    return (opcode == BEQ) || (opcode == BNE);
  endfunction

  // Unconditional jump decoded in ID.
  function automatic logic is_jump_op(input logic [5:0] opcode);
    return opcode == J;
  endfunction

  // Opcodes that write the register file in WB.
  function automatic logic writes_reg(input logic [5:0] opcode);
    return (opcode == RTYPE) || (opcode == ADDI) || (opcode == SLTI) ||
           (opcode == LUI)   || (opcode == LW);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_watchdog.sv
// hazard_watchdog: counts consecutive cycles in which 'active' is high,
// clearing as soon as it drops. 'expire' fires combinationally on the cycle
// that would bring the run length up to LIMIT. The counter saturates.
module hazard_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 5,
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expire
);

  localparam logic [CNT_W:0] LIMIT_W = (CNT_W + 1)'(LIMIT);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count} + 1'b1;
  assign expire    = active && (count_inc >= LIMIT_W);

  // Run-length counter: clears on an inactive cycle, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: central sequencer for the 5-stage pipeline.
// Produces write-enable and bubble/flush controls for every pipeline
// register from the FSM state and the current hazard/memory inputs.
// Optional build macro: HAZARD_PERF_COUNTERS_EN enables four 32-bit event
// counters; without it the perf_* ports are tied to zero.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int FILL_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int MAX_STALL   = 8,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDStall,
  input  logic        EXStall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        exmem_we,
  output logic        exmem_bubble,
  output logic        memwb_bubble,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [2:0]  state_o,
  output logic [31:0] perf_id_stall,
  output logic [31:0] perf_ex_stall,
  output logic [31:0] perf_mem_wait,
  output logic [31:0] perf_flush
);

  localparam logic [CNT_W:0] FILL_LIM = (CNT_W + 1)'(FILL_CYCLES);

  ctrl_state_t      state, state_next;
  logic [1:0]       fault_code_next;
  logic [CNT_W-1:0] fill_cnt, fill_cnt_next;
  logic             fill_done;
  logic             mem_hold;
  logic             run_active;
  logic             mem_expire;
  logic             stall_expire;

  // Memory not ready: either a new access stalls in RUN or we are still waiting.
  assign mem_hold   = ((state == RUN) && dmem_req && !dmem_ready) ||
                      ((state == MEM_WAIT) && !dmem_ready);
  // Normal hazard priority applies in RUN and on the MEM_WAIT completion cycle.
  assign run_active = ((state == RUN) || (state == MEM_WAIT)) && !mem_hold;
  assign fill_done  = ({1'b0, fill_cnt} + 1'b1) >= FILL_LIM;

  hazard_watchdog #(.CNT_W(CNT_W), .LIMIT(MEM_TIMEOUT)) u_mem_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active ((state == MEM_WAIT) && !dmem_ready),
    .expire (mem_expire)
  );

  hazard_watchdog #(.CNT_W(CNT_W), .LIMIT(MAX_STALL)) u_stall_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active ((state == RUN) && !mem_hold && (IDStall || EXStall)),
    .expire (stall_expire)
  );

  // State, fill counter and sticky fault code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      fill_cnt   <= '0;
      fault_code <= FAULT_NONE;
    end else begin
      state      <= state_next;
      fill_cnt   <= fill_cnt_next;
      fault_code <= fault_code_next;
    end
  end

  // Next-state logic; watchdog expiry only matters in the state it guards.
  always_comb begin
    state_next      = state;
    fill_cnt_next   = fill_cnt;
    fault_code_next = fault_code;
    case (state)
      FILL: begin
        if (fill_cnt != '1) fill_cnt_next = fill_cnt + 1'b1;
        if (fill_done) state_next = RUN;
      end
      RUN: begin
        if (mem_hold) begin
          state_next = MEM_WAIT;
        end else if (stall_expire) begin
          state_next      = FAULT;
          fault_code_next = FAULT_STALL_DEADLOCK;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = RUN;
        end else if (mem_expire) begin
          state_next      = FAULT;
          fault_code_next = FAULT_MEM_TIMEOUT;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = FILL;
    endcase
  end

  // Pipeline register controls; reset and FAULT park every stage on NOPs.
  always_comb begin
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    idex_we      = 1'b0;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (rst || (state == FAULT)) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
    end else if (state == FILL) begin
      // Front end fetches while ID/EX is loaded with NOPs through its write port.
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
      exmem_we    = 1'b1;
    end else if (mem_hold) begin
      memwb_bubble = 1'b1;
    end else if (run_active) begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      if (EXStall) begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_bubble = 1'b1;
      end else if (IDStall) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end else begin
        // A stalled branch is simply re-seen here once the stall clears.
        ifid_flush = branch_taken || jump;
      end
    end
  end

  assign fault   = (state == FAULT);
  assign state_o = state;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] perf_id_stall_reg, perf_ex_stall_reg, perf_mem_wait_reg, perf_flush_reg;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_id_stall_reg <= '0;
      perf_ex_stall_reg <= '0;
      perf_mem_wait_reg <= '0;
      perf_flush_reg    <= '0;
    end else begin
      if (run_active && !EXStall && IDStall) perf_id_stall_reg <= perf_id_stall_reg + 1'b1;
      if (run_active && EXStall)             perf_ex_stall_reg <= perf_ex_stall_reg + 1'b1;
      if ((state == MEM_WAIT) && !dmem_ready) perf_mem_wait_reg <= perf_mem_wait_reg + 1'b1;
      if (ifid_flush)                        perf_flush_reg    <= perf_flush_reg + 1'b1;
    end
  end

  assign perf_id_stall = perf_id_stall_reg;
  assign perf_ex_stall = perf_ex_stall_reg;
  assign perf_mem_wait = perf_mem_wait_reg;
  assign perf_flush    = perf_flush_reg;
`else
  assign perf_id_stall = '0;
  assign perf_ex_stall = '0;
  assign perf_mem_wait = '0;
  assign perf_flush    = '0;
`endif

endmodule
